// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard between ID and EX: per-register latency countdown for RAW/WAW
// stalls, a redirect-flush state machine covering fetch latency, and a stall counter.
module hazard_scoreboard_unit #(
  parameter int NREG        = 32,
  parameter int AW          = 5,
  parameter int LW          = 3,
  parameter int FLUSH_EXTRA = 0,
  parameter int CW          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_we,
  input  logic [LW-1:0]   id_lat,
  input  logic            id_jump,
  input  logic            ex_redirect,
  output logic            stall_pc,
  output logic            stall_id,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   stall_cnt
);

  localparam int FW = (FLUSH_EXTRA > 0) ? $clog2(FLUSH_EXTRA + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state;
  logic [FW-1:0]   fcnt;
  logic [LW-1:0]   cnt [NREG];
  logic [NREG-1:0] pend;
  logic [CW-1:0]   stall_cnt_q;

  logic raw, waw, hz, flushing, stall, issue, sb_write, jump_flush;

  // Hazard detection works purely on the current countdown values.
  always_comb begin
    raw = id_valid & ((id_rs1_used & (cnt[id_rs1] != '0)) |
                      (id_rs2_used & (cnt[id_rs2] != '0)));
    // A slower producer still in flight must not be overtaken by a faster write.
    waw = id_valid & id_we & (id_rd != '0) & (cnt[id_rd] > id_lat);
    hz  = raw | waw;
  end

  assign flushing   = ex_redirect | (state == FLUSH);
  assign stall      = hz & ~flushing;
  assign issue      = id_valid & ~hz & ~ex_redirect & (state == IDLE);
  assign sb_write   = issue & id_we & (id_rd != '0) & (id_lat != '0);
  assign jump_flush = id_jump & id_valid & ~hz;

  // NOTE: the scoreboard array must be reset -- a stale nonzero count would
  // stall dependants forever after reset, unlike a data RAM that is written first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments let the issue write below override the
      // decrement for the same entry; the last scheduled update wins.
      for (int r = 1; r < NREG; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
      if (sb_write) cnt[id_rd] <= id_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_redirect && (FLUSH_EXTRA > 0)) begin
            state <= FLUSH;
            fcnt  <= FW'(FLUSH_EXTRA);
          end
        end
        FLUSH: begin
          if (ex_redirect) begin
            fcnt <= FW'(FLUSH_EXTRA);
          end else if (fcnt == FW'(1)) begin
            state <= IDLE;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          fcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NREG; r++) pend[r] = (cnt[r] != '0);
  end

  // Outputs are forced low while reset is asserted, before the reset edge lands.
  assign stall_pc    = rst_n & stall;
  assign stall_id    = rst_n & stall;
  assign flush_id_ex = rst_n & (stall | flushing);
  assign flush_if_id = rst_n & (flushing | jump_flush);
  assign pending     = rst_n ? pend : '0;
  assign stall_cnt   = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: load-use, multi-cycle, WAW/x0,
// redirect priority, extended flush, jump, reset and counter saturation.
module tb_hazard_scoreboard_unit;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LW   = 3;
  localparam int FE   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used, id_we;
  logic [LW-1:0]   id_lat;
  logic            id_jump, ex_redirect;
  logic            stall_pc, stall_id, flush_if_id, flush_id_ex;
  logic [NREG-1:0] pending;
  logic [CW-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_unit #(
    .NREG(NREG), .AW(AW), .LW(LW), .FLUSH_EXTRA(FE), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_lat(id_lat),
    .id_jump(id_jump), .ex_redirect(ex_redirect),
    .stall_pc(stall_pc), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled 1 unit later.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic we, input logic [LW-1:0] lat,
                       input logic jmp, input logic redir);
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd;    id_we = we;   id_lat = lat;     id_jump = jmp; ex_redirect = redir;
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with busy inputs: everything must read 0.
    rst_n = 1'b0;
    drive(1, 5, 1, 7, 1, 9, 1, 3, 1, 1);
    check("rst_stall_pc", stall_pc, 0);
    check("rst_flush_if_id", flush_if_id, 0);
    check("rst_flush_id_ex", flush_id_ex, 0);
    cyc; cyc;
    check("rst_pending", pending, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    idle;
    check("post_rst_flush", flush_if_id, 0);

    // Load-use: one bubble.
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    check("lu_load_issue", stall_pc, 0);
    cyc;
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check("lu_stall_pc", stall_pc, 1);
    check("lu_stall_id", stall_id, 1);
    check("lu_flush_id_ex", flush_id_ex, 1);
    check("lu_pending", pending, 32'h20);
    cyc;
    check("lu_released", stall_pc, 0);
    check("lu_pending_clr", pending, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    cyc;

    // Multi-cycle divide, latency 4: four bubbles.
    drive(1, 0, 0, 0, 0, 7, 1, 4, 0, 0);
    check("div_issue", stall_pc, 0);
    cyc;
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("div_stall%0d", i), stall_pc, 1);
      cyc;
    end
    check("div_released", stall_pc, 0);
    check("div_pending_clr", pending, 0);
    check("div_stall_cnt", stall_cnt, 5);
    cyc;
    drive(1, 0, 0, 0, 0, 7, 1, 4, 0, 0);
    cyc;
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("unrelated_no_stall", stall_pc, 0);
    check("unrelated_pending", pending, 32'h80);
    cyc;
    idle;
    cyc; cyc; cyc;
    check("div_drained", pending, 0);

    // WAW: ALU write to r9 waits for cnt[9] to reach 0.
    drive(1, 0, 0, 0, 0, 9, 1, 3, 0, 0);
    cyc;
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("waw_stall%0d", i), stall_pc, 1);
      cyc;
    end
    check("waw_released", stall_pc, 0);
    cyc;
    drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0);
    cyc;
    drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0);
    check("waw_equal_lat_no_stall", stall_pc, 0);
    cyc;
    idle;
    cyc; cyc;
    check("waw_drained", pending, 0);
    check("waw_stall_cnt", stall_cnt, 8);

    // Writes to x0 are ignored.
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    check("x0_load_no_stall", stall_pc, 0);
    cyc;
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("x0_pending", pending, 0);
    check("x0_reader_no_stall", stall_pc, 0);
    cyc;

    // Redirect beats a live hazard; FLUSH lasts two extra cycles.
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    cyc;
    drive(1, 5, 1, 0, 0, 6, 1, 2, 0, 1);
    check("redir_stall_pc", stall_pc, 0);
    check("redir_stall_id", stall_id, 0);
    check("redir_flush_if_id", flush_if_id, 1);
    check("redir_flush_id_ex", flush_id_ex, 1);
    cyc;
    drive(1, 5, 1, 0, 0, 6, 1, 2, 0, 0);
    check("redir_stall_cnt", stall_cnt, 8);
    check("redir_no_issue", pending, 0);
    check("flush_c2", flush_if_id, 1);
    check("flush_c2_stall_pc", stall_pc, 0);
    cyc;
    check("flush_c3", flush_if_id, 1);
    check("flush_c3_no_issue", pending, 0);
    cyc;
    check("flush_c4_done", flush_if_id, 0);
    check("flush_c4_issue", stall_pc, 0);
    cyc;
    idle;
    check("post_flush_issue", pending, 32'h40);
    cyc; cyc;

    // Second redirect in the first FLUSH cycle reloads the count.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rr_c1", flush_if_id, 1);
    cyc;
    check("rr_c2", flush_if_id, 1);
    cyc;
    idle;
    check("rr_c3", flush_if_id, 1);
    cyc;
    check("rr_c4", flush_if_id, 1);
    check("rr_c4_id_ex", flush_id_ex, 1);
    cyc;
    check("rr_c5_done", flush_if_id, 0);
    check("rr_c5_id_ex", flush_id_ex, 0);

    // Jump in ID flushes IF/ID only when not stalled.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("jump_flush_if_id", flush_if_id, 1);
    check("jump_no_id_ex", flush_id_ex, 0);
    cyc;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    cyc;
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 0);
    check("jump_hz_no_flush", flush_if_id, 0);
    check("jump_hz_stall", stall_pc, 1);
    cyc;
    check("jump_after_hz", flush_if_id, 1);
    check("jump_stall_cnt", stall_cnt, 9);
    cyc;

    // Reset mid-operation: cnt[5]=2 and FLUSH both discarded.
    drive(1, 0, 0, 0, 0, 5, 1, 3, 0, 0);
    cyc;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc;
    idle;
    check("pre_rst_pending", pending, 32'h20);
    check("pre_rst_flush", flush_if_id, 1);
    rst_n = 1'b0;
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 1);
    check("mid_rst_flush_if_id", flush_if_id, 0);
    check("mid_rst_flush_id_ex", flush_id_ex, 0);
    check("mid_rst_pending", pending, 0);
    cyc;
    rst_n = 1'b1;
    idle;
    check("after_rst_pending", pending, 0);
    check("after_rst_flush", flush_if_id, 0);
    check("after_rst_stall_cnt", stall_cnt, 0);
    cyc;
    check("after_rst_idle", flush_if_id, 0);

    // Saturation of the 4-bit stall counter: 3 x 7 stalls.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 7, 0, 0);
      cyc;
      drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc;
      check($sformatf("sat_round%0d_release", k), stall_pc, 0);
      if (k == 1) check("sat_pre", stall_cnt, 14);
      cyc;
    end
    check("sat_final", stall_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use hazard logic in the in-order pipeline.
- Keeps a per-register countdown scoreboard, so producers of any latency (loads, multi-cycle mul/div) stall only their real dependants.
- Runs a redirect-flush state machine that covers multi-cycle instruction fetch.
- Sits between the ID and EX stages and drives the PC, IF/ID and ID/EX stall and flush controls, plus a stall performance counter.

Parameters:
- NREG, 32: number of architectural registers. x0 is hardwired and never pending.
- AW, 5: register index width, equal to $clog2(NREG).
- LW, 3: width of the latency class field. Maximum latency is 2^LW-1.
- FLUSH_EXTRA, 0: extra cycles the fetch side stays flushed after a redirect (instruction-memory latency).
- CW, 16: width of the stall performance counter.

Ports:
- clk, in, 1: clock. Single clock domain.
- rst_n, in, 1: reset, synchronous and active-low.
- id_valid, in, 1: ID holds a valid instruction.
- id_rs1, in, AW: ID source register 1.
- id_rs2, in, AW: ID source register 2.
- id_rs1_used, in, 1: instruction actually reads rs1.
- id_rs2_used, in, 1: instruction actually reads rs2.
- id_rd, in, AW: ID destination register.
- id_we, in, 1: instruction writes rd.
- id_lat, in, LW: cycles until the result is forwardable. 0 = ALU (no stall), 1 = load.
- id_jump, in, 1: unconditional jump resolved in ID.
- ex_redirect, in, 1: branch or jump mispredict resolved in EX.
- stall_pc, out, 1: hold PC.
- stall_id, out, 1: hold the IF/ID register.
- flush_if_id, out, 1: bubble the IF/ID register.
- flush_id_ex, out, 1: bubble the ID/EX register.
- pending, out, NREG: bit r is 1 when cnt[r] != 0 (debug).
- stall_cnt, out, CW: saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - all cnt[r] are cleared to 0, the FSM goes to IDLE, stall_cnt is cleared to 0.
  - All outputs read 0 while rst_n=0, regardless of the other inputs.
- Scoreboard: cnt[r] is an LW-bit counter per register.
  - Each cycle, every nonzero cnt decrements by 1.
  - On issue, the issued write overrides the decrement for its rd.
- Hazard (combinational, from current cnt):
  - raw = id_valid & ((id_rs1_used & cnt[id_rs1]!=0) | (id_rs2_used & cnt[id_rs2]!=0)).
  - waw = id_valid & id_we & id_rd!=0 & cnt[id_rd] > id_lat. This enforces in-order writeback.
  - hz = raw | waw.
- Issue: issue = id_valid & ~hz & ~ex_redirect & state==IDLE.
  - When issue & id_we & id_rd!=0 & id_lat!=0, cnt[id_rd] <= id_lat.
  - Writes to x0 are ignored.
- Stall outputs:
  - When hz and there is no redirect or flush: stall_pc=1, stall_id=1, flush_id_ex=1 (bubble into EX).
  - A load (id_lat=1) followed by a dependant yields exactly one bubble. A latency-N producer yields N bubbles to an immediate dependant.
- Jump in ID: id_jump & id_valid & ~hz gives flush_if_id=1 for one cycle.
- Redirect:
  - In the cycle ex_redirect=1: flush_if_id=1, flush_id_ex=1, stall_pc=0, stall_id=0.
  - Redirect has priority over hz and id_jump.
  - The scoreboard is not cleared: older in-flight producers still complete.
- FSM states and transitions:
  - IDLE: on ex_redirect with FLUSH_EXTRA>0, go to FLUSH with fcnt=FLUSH_EXTRA.
  - FLUSH: flush_if_id=1, flush_id_ex=1, stall_pc=0, stall_id=0, no issue. fcnt decrements each cycle; return to IDLE after the cycle in which fcnt==1.
  - A new ex_redirect in FLUSH reloads fcnt to FLUSH_EXTRA.
  - With FLUSH_EXTRA=0, FLUSH is never entered.
- stall_cnt: increments in each cycle where hz causes a stall (stall_pc=1). It saturates at 2^CW-1 and does not wrap.
- Reset mid-operation: all pending state and the FLUSH state are discarded on the same edge.

Test Plan:
- Load-use: issue load with rd=5, id_lat=1; next cycle ID has rs1=5 -> stall_pc=stall_id=flush_id_ex=1 for exactly 1 cycle, then issue; stall_cnt=1.
- Multi-cycle: issue div with rd=7, id_lat=4; next cycle ID has rs2=7 -> 4 stall cycles, pending[7] cleared after them; an unrelated rs=3 instruction issues with no stall.
- WAW and x0: pending cnt[9]=3, ID is ALU with rd=9, lat=0 -> stall until cnt[9]=0; a load to rd=0 leaves pending=0 and never stalls.
- Redirect over stall: hz active and ex_redirect=1 same cycle -> stall_pc=0, flush_if_id=flush_id_ex=1, no issue, stall_cnt unchanged.
- FLUSH_EXTRA=2: redirect -> flush_if_id high 3 cycles total; a second redirect in cycle 2 extends it to 4 cycles total.
- Reset: rst_n=0 while cnt[5]=2 and in FLUSH -> next cycle all outputs 0, pending=0; stall_cnt forced to 2^CW-1 then another stall -> stays 2^CW-1.
